image_filter: RTL and testbench
===============================

Name: image_filter

Overview:
- Streaming 3x3 2-D convolution engine for small grayscale frames. Default frame is 10x10, 8-bit pixels.
- Accepts pixels in raster order and holds 9 programmable coefficients.
- Emits the valid-region result: 8x8 = 64 outputs per frame, 16 bits each, in raster order.
- Sits between a pixel source (frame buffer/DMA) and a result sink; no backpressure.

Parameters:
- IMG_W, 10, pixels per row (>=3)
- IMG_H, 10, rows per frame (>=3)
- PIX_W, 8, pixel width, unsigned
- COEF_W, 8, coefficient width, unsigned
- OUT_W, 16, output width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  coefficient index 0..8, raster order in window (0 = top-left, 8 = bottom-right); 9..15 ignored
- coef_data  in  COEF_W  coefficient value
- pix_valid  in  1  pixel present this cycle
- pix_data  in  PIX_W  pixel value
- out_valid  out  1  result valid, one-cycle pulse per result
- out_data  out  OUT_W  convolution result
- out_idx  out  6  result index 0..(IMG_W-2)*(IMG_H-2)-1, raster order
- frame_done  out  1  one-cycle pulse coincident with the last result of a frame

Behaviour:
- Reset (rst=0, async): all outputs 0; col/row counters 0; coefficients 0; line buffers and window cleared.
- Pixel accept: pix_valid=1 on a rising edge.
  - Gaps (pix_valid=0) are allowed anywhere; state holds.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At the last pixel (row IMG_H-1, col IMG_W-1) both counters wrap to 0 and the next pixel starts a new frame.
- Storage: two line buffers of IMG_W pixels plus a 3x3 window register shift on each accepted pixel.
- A window is complete when the accepted pixel has row>=2 and col>=2.
- Window position: result (r,c) uses rows r..r+2 and cols c..c+2. out_idx = r*(IMG_W-2)+c.
- Arithmetic:
  - sum = Σ coef[k]*win[k], unsigned, with a full-precision accumulator (PIX_W+COEF_W+4 bits).
  - sum is reduced to OUT_W bits per the Optional Feature.
- Pipeline, with the completing pixel accepted at edge N:
  - edge N: window update
  - edge N+1: 9 products registered
  - edge N+2: sum, out_valid, out_idx and frame_done registered
  - A fixed 3-edge latency; out_valid is high for exactly one cycle per result.
- Throughput: one result per clock when pix_valid is continuously high.
- Coefficient write:
  - coef_we=1 writes coef[coef_addr] at the edge.
  - The new value is used by any window entering the product stage at a later edge.
  - Writing in the same cycle as a pixel is allowed.
  - The bench keeps coefficients stable within a frame.
- Reset mid-frame: partial frame discarded, in-flight pipeline results dropped (no out_valid), coefficients return to 0. The next accepted pixel is pixel (0,0).
- No outputs are produced for border columns/rows (cols 0-1, rows 0-1 of the stream).

Optional Feature:
- Macro IMAGE_FILTER_SAT_EN.
- Defined: sum > 2^OUT_W-1 clamps to 2^OUT_W-1.
- Undefined: out_data = sum[OUT_W-1:0] (wrap-around truncation).
- No other behaviour or latency difference.

Test Plan:
- Ramp frame, all coefficients 1:
  - Stimulus: write coef[0..8]=1; stream pixels 1..100 continuously.
  - Response: 64 out_valid pulses. Result (r,c) = 9*(10r+c+12): idx0=108, idx7=171, idx56=738, idx63=801.
  - frame_done coincides with idx63.
  - First out_valid comes 2 edges after the edge accepting pixel value 23 (row2,col2).
- Identity kernel:
  - Stimulus: coef[4]=1, others 0; ramp frame.
  - Response: result (r,c) = 10r+c+12, so idx0=12 and idx63=89.
- Gapped input: ramp frame with pix_valid toggling 1/0 every cycle, all-ones kernel -> identical 64 values and indices; no extra or missing pulses.
- Overflow: all pixels 255, all coefficients 255 (sum 585225) -> out_data=65535 with IMAGE_FILTER_SAT_EN, 60937 without.
- Reset mid-frame:
  - Stimulus: assert rst after 45 pixels, release, rewrite coefficients to 1, stream a full ramp frame.
  - Response: out_valid stays 0 during reset. The second frame gives exactly 64 results, idx0=108.
- Back-to-back frames: two ramp frames with no gap -> 128 results, idx wraps 63 -> 0, frame_done pulses twice.

Source files
------------

// File: rtl/image_filter.sv
// image_filter: streaming 3x3 convolution over raster-order grayscale frames.
// Two line buffers plus a 3x3 window feed a registered product stage and a
// registered adder stage, so a result appears three edges after the pixel
// that completes its window.
// Build option: define IMAGE_FILTER_SAT_EN to clamp oversized sums to the
// largest OUT_W value. Without it the sum is truncated to OUT_W bits.
module image_filter #(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [5:0]        out_idx,
    output logic              frame_done
);

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PROD_W = PIX_W + COEF_W;
    localparam int ACC_W  = PROD_W + 4;

    // Raster position of the incoming pixel and running result index.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [5:0]    idx_q, idx_d;

    logic [COEF_W-1:0] coef_q [9];
    logic [PIX_W-1:0]  lb0_q  [IMG_W];   // previous row
    logic [PIX_W-1:0]  lb1_q  [IMG_W];   // row before that
    logic [PIX_W-1:0]  win_q  [9];       // index = 3*row + col, 0 = top-left
    logic [PIX_W-1:0]  col_in [3];       // new right-hand window column, top first

    logic              v0_q, fd0_q, v1_q, fd1_q;
    logic [5:0]        idx0_q, idx1_q;
    logic [PROD_W-1:0] prod_d [9];
    logic [PROD_W-1:0] prod_q [9];
    logic [ACC_W-1:0]  acc_sum;
    logic [OUT_W-1:0]  res_d;

    logic              out_valid_q, frame_done_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [5:0]        out_idx_q;

    logic last_col, last_row, frame_end, win_done;

    assign last_col  = (col_q == CW'(IMG_W - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign frame_end = last_col && last_row;
    assign win_done  = pix_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign col_in[0] = lb1_q[col_q];
    assign col_in[1] = lb0_q[col_q];
    assign col_in[2] = pix_data;

    // Advance the raster counters and result index on each accepted pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        idx_d = idx_q;
        if (pix_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (win_done) begin
                idx_d = frame_end ? '0 : idx_q + 6'd1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            idx_q <= idx_d;
        end
    end

    // Coefficient bank; addresses 9..15 match no entry and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 9; k++) coef_q[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < 9; k++) begin
                if (coef_addr == 4'(k)) coef_q[k] <= coef_data;
            end
        end
    end

    // Line buffers and window shift left by one column per accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else if (pix_valid) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_data;
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]     <= win_q[3*r + 1];
                win_q[3*r + 1] <= win_q[3*r + 2];
                win_q[3*r + 2] <= col_in[r];
            end
        end
    end

    // One multiplier per window tap.
    for (genvar gi = 0; gi < 9; gi++) begin : g_prod
        assign prod_d[gi] = PROD_W'(coef_q[gi]) * PROD_W'(win_q[gi]);
    end

    // Sum the registered products at full precision.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < 9; k++) acc_sum = acc_sum + ACC_W'(prod_q[k]);
    end

`ifdef IMAGE_FILTER_SAT_EN
    assign res_d = (acc_sum[ACC_W-1:OUT_W] != '0) ? '1 : acc_sum[OUT_W-1:0];
`else
    logic sum_unused;
    assign sum_unused = ^acc_sum[ACC_W-1:OUT_W];
    assign res_d      = acc_sum[OUT_W-1:0];
`endif

    // Pipeline: window tag stage, product stage, result stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q         <= 1'b0;
            fd0_q        <= 1'b0;
            idx0_q       <= '0;
            v1_q         <= 1'b0;
            fd1_q        <= 1'b0;
            idx1_q       <= '0;
            for (int k = 0; k < 9; k++) prod_q[k] <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
        end else begin
            v0_q         <= win_done;
            fd0_q        <= win_done && frame_end;
            idx0_q       <= idx_q;
            v1_q         <= v0_q;
            fd1_q        <= fd0_q;
            idx1_q       <= idx0_q;
            for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
            out_valid_q  <= v1_q;
            frame_done_q <= fd1_q;
            out_idx_q    <= idx1_q;
            if (v1_q) out_data_q <= res_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_filter.sv
// Scoreboard bench for image_filter: the driver computes each expected
// result from a 2-D copy of the frame and queues it with its due cycle; a
// negedge monitor pops and compares whenever out_valid is seen.
module tb_image_filter;

    localparam int W = 10;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        frame_done;

    image_filter dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .pix_valid(pix_valid), .pix_data(pix_data),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned data;
        int unsigned idx;
        bit          fd;
        int unsigned t;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_coef[9];
    int unsigned m_img[H][W];
    int          m_row = 0;
    int          m_col = 0;

    function automatic void chk(string nm, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Convolution of the window whose top-left pixel is (r,c).
    function automatic int unsigned ref_result(int r, int c);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(m_coef[3*i + j]) * longint'(m_img[r+i][c+j]);
`ifdef IMAGE_FILTER_SAT_EN
        if (s > 65535) s = 65535;
        return int'(s);
`else
        return int'(s % 65536);
`endif
    endfunction

    // Drive one cycle of inputs and update the reference model.
    task automatic drive(bit pv, int unsigned pd, bit we, int unsigned ad, int unsigned cd);
        exp_t e;
        @(negedge clk);
        pix_valid = pv;
        pix_data  = 8'(pd);
        coef_we   = we;
        coef_addr = 4'(ad);
        coef_data = 8'(cd);
        if (we && ad < 9) m_coef[ad] = cd;
        if (pv) begin
            m_img[m_row][m_col] = pd;
            if (m_row >= 2 && m_col >= 2) begin
                e.data = ref_result(m_row - 2, m_col - 2);
                e.idx  = (m_row - 2) * (W - 2) + (m_col - 2);
                e.fd   = (m_row == H - 1) && (m_col == W - 1);
                e.t    = cyc + 3;
                sbq.push_back(e);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic all_coefs(int unsigned v);
        for (int k = 0; k < 9; k++) drive(0, 0, 1, k, v);
    endtask

    task automatic ramp_frame(bit gapped);
        for (int p = 0; p < W * H; p++) begin
            drive(1, p + 1, 0, 0, 0);
            if (gapped) drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        pix_valid = 1'b0;
        coef_we = 1'b0;
        sbq.delete();
        for (int k = 0; k < 9; k++) m_coef[k] = 0;
        m_row = 0;
        m_col = 0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_frame_done", frame_done, 0);
        end
        #2 rst = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: compare every presented result against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got idx %0d data %0d, expected no result (cycle %0d)",
                             out_idx, out_data, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_idx", out_idx, mon_e.idx);
                    chk("frame_done", frame_done, mon_e.fd);
                    chk("latency_cycle", cyc, mon_e.t);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
                if (sbq.size() != 0 && sbq[0].t < cyc) begin
                    mon_e = sbq.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_out: got no result, expected idx %0d data %0d at cycle %0d",
                             mon_e.idx, mon_e.data, mon_e.t);
                end
            end
        end
    end

    initial begin
        do_reset(2);

        // Ramp with all-ones kernel.
        all_coefs(1);
        ramp_frame(0);
        drain();

        // Identity kernel.
        all_coefs(0);
        drive(0, 0, 1, 4, 1);
        ramp_frame(0);
        drain();

        // Gapped ramp, all-ones kernel.
        all_coefs(1);
        ramp_frame(1);
        drain();

        // Overflow: all 255.
        all_coefs(255);
        for (int p = 0; p < W * H; p++) drive(1, 255, 0, 0, 0);
        drain();

        // Reset mid-frame, then a clean ramp frame.
        all_coefs(1);
        for (int p = 0; p < 45; p++) drive(1, p + 1, 0, 0, 0);
        do_reset(3);
        all_coefs(1);
        ramp_frame(0);
        drain();

        // Back-to-back frames.
        ramp_frame(0);
        ramp_frame(0);
        drain();

        // Random kernels, pixels and gaps; stray writes to unused addresses.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 9; k++) drive(0, 0, 1, k, $urandom_range(0, 255));
            for (int p = 0; p < W * H; p++) begin
                while ($urandom_range(0, 3) == 0)
                    drive(0, 0, $urandom_range(0, 1), $urandom_range(9, 15), $urandom_range(0, 255));
                drive(1, $urandom_range(0, 255), 0, 0, 0);
            end
        end
        drain();

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion within 2000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
